multi_sensor_frame_bridge: RTL

Parametrised successor to the single-sensor bridge between the Arduino SPI receiver and the MCU SPI slave. It latches the latest quaternion and gyro sample from NUM_CH sensor channels and tracks freshness, staleness and a sequence count per channel. On each MCU transaction start it takes an atomic snapshot of all channels. It then serves that snapshot as a checksummed byte stream to an MCU-side SPI shifter over a byte request/response handshake.

---
 rtl/multi_sensor_frame_bridge.sv | 110 +++++++++++
 1 files changed

// File: rtl/multi_sensor_frame_bridge.sv
// multi_sensor_frame_bridge: latches per-channel IMU samples and serves atomic checksummed snapshots to an MCU byte shifter
module multi_sensor_frame_bridge #(
  parameter int          NUM_CH       = 2,
  parameter int          STALE_CYCLES = 24000000,
  parameter logic [7:0]  HEADER       = 8'hA5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_CH-1:0]    ch_quat_valid,
  input  logic [NUM_CH*64-1:0] ch_quat,
  input  logic [NUM_CH-1:0]    ch_gyro_valid,
  input  logic [NUM_CH*48-1:0] ch_gyro,
  input  logic [NUM_CH-1:0]    ch_error,
  input  logic                 frame_start,
  input  logic                 frame_end,
  input  logic                 byte_req,
  output logic [7:0]           byte_data,
  output logic                 byte_valid,
  output logic                 busy,
  output logic                 overrun
);
  localparam int LEN = 3 + 15 * NUM_CH;
  localparam int SW = $clog2(STALE_CYCLES + 1);
  localparam logic [SW-1:0] STALE_MAX = SW'(STALE_CYCLES);
  localparam logic [7:0] LEN8 = 8'(LEN);
  typedef enum logic {IDLE, SERVE} state_t;
  state_t r_state, w_next;
  logic [63:0] r_quat [NUM_CH];
  logic [47:0] r_gyro [NUM_CH];
  logic [SW-1:0] r_stale [NUM_CH];
  logic [3:0] r_seq [NUM_CH];
  logic [NUM_CH-1:0] r_qf, r_gf;
  logic [NUM_CH*120-1:0] r_snap, w_live;
  logic [7:0] r_frame, r_idx, r_sum, r_byte, w_sel, w_body, w_byte;
  logic r_valid, r_over;
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        r_quat[c] <= '0;
        r_gyro[c] <= '0;
        r_stale[c] <= '0;
        r_seq[c] <= '0;
      end
      r_qf <= '0;
      r_gf <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (ch_quat_valid[c]) begin
          r_quat[c] <= ch_quat[c*64 +: 64];
          r_seq[c] <= r_seq[c] + 4'd1;
          r_stale[c] <= '0;
        end else if (r_stale[c] != STALE_MAX) r_stale[c] <= r_stale[c] + 1'b1;
        if (ch_gyro_valid[c]) r_gyro[c] <= ch_gyro[c*48 +: 48];
      end
      // a strobe in the snapshot cycle survives the clear and marks the next packet fresh
      r_qf <= ch_quat_valid | (frame_start ? '0 : r_qf);
      r_gf <= ch_gyro_valid | (frame_start ? '0 : r_gf);
    end
  end
  // channel 0 sits in the MSBs so body byte k is simply the k-th byte from the top
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign w_live[(NUM_CH-1-c)*120 +: 120] = {r_qf[c], r_gf[c], r_stale[c] == STALE_MAX, ch_error[c],
                                              r_seq[c], r_quat[c], r_gyro[c]};
  end
  always_comb begin
    w_sel = 8'(LEN - 2) - r_idx;
    w_body = 8'(r_snap >> {w_sel, 3'b000});
    w_byte = (r_idx == 8'd0) ? HEADER : (r_idx == 8'd1) ? r_frame : (r_idx == LEN8 - 8'd1) ? r_sum : w_body;
  end
  always_ff @(posedge clk) r_state <= rst ? IDLE : w_next;
  always_comb begin
    w_next = r_state;
    if (frame_start) w_next = SERVE;
    else if (frame_end) w_next = IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_snap <= '0;
      r_frame <= '0;
      r_idx <= '0;
      r_sum <= '0;
      r_byte <= '0;
      r_valid <= 1'b0;
      r_over <= 1'b0;
    end else begin
      r_valid <= byte_req;
      if (frame_start) begin
        r_snap <= w_live;
        r_frame <= r_frame + 8'd1;
        r_idx <= '0;
        r_sum <= '0;
        r_over <= 1'b0;
        if (byte_req) r_byte <= '0;
      end else if (byte_req) begin
        if (r_state == SERVE && r_idx < LEN8) begin
          r_byte <= w_byte;
          r_idx <= r_idx + 8'd1;
          if (r_idx < LEN8 - 8'd1) r_sum <= r_sum + w_byte;
        end else begin
          r_byte <= '0;
          if (r_state == SERVE) r_over <= 1'b1;
        end
      end
    end
  end
  assign byte_data = r_byte;
  assign byte_valid = r_valid;
  assign busy = (r_state == SERVE);
  assign overrun = r_over;
endmodule
